// File: rtl/conv_mem_host.sv
// Host-side controller for a convolution accelerator: image/layer memories,
// launch handshake FSM, write-acceptance checks, counters and sticky error flags.
module conv_mem_host #(
   parameter int READY_DLY = 2,
   parameter int BUSY_TMO  = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ld_en,
   input  logic [11:0] ld_addr,
   input  logic [19:0] ld_data,
   output logic        ready,
   input  logic        busy,
   input  logic [11:0] iaddr,
   output logic [19:0] idata,
   input  logic        cwr,
   input  logic [11:0] caddr_wr,
   input  logic [19:0] cdata_wr,
   input  logic        crd,
   input  logic [11:0] caddr_rd,
   output logic [19:0] cdata_rd,
   input  logic [2:0]  csel,
   input  logic        dp_sel,
   input  logic [11:0] dp_addr,
   output logic [19:0] dp_data,
   output logic        done,
   output logic        err_proto,
   output logic        err_csel,
   output logic        err_range,
   output logic        err_tmo,
   output logic [12:0] wr_cnt_l0,
   output logic [10:0] wr_cnt_l1
);

   typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, RUN, DONE} state_t;

   localparam int              TMO_W    = (BUSY_TMO > 1) ? $clog2(BUSY_TMO + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
   localparam logic [3:0]      DLY_LAST = 4'(READY_DLY - 1);

   logic [19:0] img_mem [4096];
   logic [19:0] l0_mem  [4096];
   logic [19:0] l1_mem  [1024];

   state_t            state;
   logic [3:0]        dly_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              busy_q;
   logic [19:0]       rd_hold;

   logic idle_like, start_acc, in_run;
   logic csel_l0, csel_l1, csel_ok;
   logic img_wr, l0_wr, l1_wr, rd_ok;
   logic [19:0] rd_word;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign start_acc = start && idle_like;
   assign in_run    = (state == RUN);
   assign csel_l0   = (csel == 3'b001);
   assign csel_l1   = (csel == 3'b011);
   assign csel_ok   = csel_l0 || csel_l1;

   assign img_wr = ld_en && idle_like;
   assign l0_wr  = in_run && cwr && csel_l0;
   assign l1_wr  = in_run && cwr && csel_l1 && (caddr_wr[11:10] == 2'b00);
   assign rd_ok  = in_run && crd && csel_ok;

   assign rd_word  = csel_l1 ? l1_mem[caddr_rd[9:0]] : l0_mem[caddr_rd];
   // A valid read is combinational; otherwise the last valid read word is held.
   assign cdata_rd = rd_ok ? rd_word : rd_hold;
   assign idata    = img_mem[iaddr];
   assign dp_data  = dp_sel ? l1_mem[dp_addr[9:0]] : l0_mem[dp_addr];

   // NOTE: storage arrays carry no reset; a reset must not wipe results, and
   // resetting thousands of words would prevent RAM inference.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (img_wr) img_mem[ld_addr] <= ld_data;
         if (l0_wr)  l0_mem[caddr_wr] <= cdata_wr;
         if (l1_wr)  l1_mem[caddr_wr[9:0]] <= cdata_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ready     <= 1'b0;
         done      <= 1'b0;
         dly_cnt   <= '0;
         tmo_cnt   <= '0;
         busy_q    <= 1'b0;
         rd_hold   <= '0;
         err_proto <= 1'b0;
         err_csel  <= 1'b0;
         err_range <= 1'b0;
         err_tmo   <= 1'b0;
         wr_cnt_l0 <= '0;
         wr_cnt_l1 <= '0;
      end else begin
         ready  <= 1'b0;
         busy_q <= busy;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= ARM;
                  dly_cnt <= '0;
                  done    <= 1'b0;
               end
            end
            ARM: begin
               if (dly_cnt == DLY_LAST) begin
                  ready   <= 1'b1;
                  state   <= WAIT_BUSY;
                  tmo_cnt <= '0;
               end else begin
                  dly_cnt <= dly_cnt + 4'd1;
               end
            end
            WAIT_BUSY: begin
               if (busy) begin
                  state <= RUN;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_tmo <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RUN: begin
               if (busy_q && !busy) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase

         // Start clears the sticky flags and counters; a fresh error in the
         // same cycle still wins because it is assigned afterwards.
         if (start_acc) begin
            err_proto <= 1'b0;
            err_csel  <= 1'b0;
            err_range <= 1'b0;
            err_tmo   <= 1'b0;
            wr_cnt_l0 <= '0;
            wr_cnt_l1 <= '0;
         end

         if ((ld_en && !idle_like) || ((cwr || crd) && !in_run))
            err_proto <= 1'b1;
         if (in_run && (cwr || crd) && !csel_ok)
            err_csel <= 1'b1;
         if (in_run && cwr && csel_l1 && (caddr_wr[11:10] != 2'b00))
            err_range <= 1'b1;

         if (l0_wr && (wr_cnt_l0 != 13'd4096))
            wr_cnt_l0 <= wr_cnt_l0 + 13'd1;
         if (l1_wr && (wr_cnt_l1 != 11'd1024))
            wr_cnt_l1 <= wr_cnt_l1 + 11'd1;

         if (rd_ok)
            rd_hold <= rd_word;
      end
   end

endmodule

// File: tb/tb_conv_mem_host.sv
// Scenario-per-task bench for conv_mem_host; expected memory words travel
// through a scoreboard queue from the write that creates them to the read.
module tb_conv_mem_host;

   logic        clk = 1'b0;
   logic        reset, start, ld_en, busy, cwr, crd, dp_sel;
   logic [11:0] ld_addr, iaddr, caddr_wr, caddr_rd, dp_addr;
   logic [19:0] ld_data, cdata_wr;
   logic [2:0]  csel;
   logic        ready, done, err_proto, err_csel, err_range, err_tmo;
   logic [19:0] idata, cdata_rd, dp_data;
   logic [12:0] wr_cnt_l0;
   logic [10:0] wr_cnt_l1;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q [$];
   logic [19:0] exp_w;

   conv_mem_host #(.READY_DLY(2), .BUSY_TMO(1023)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .csel(csel), .dp_sel(dp_sel), .dp_addr(dp_addr), .dp_data(dp_data),
      .done(done), .err_proto(err_proto), .err_csel(err_csel),
      .err_range(err_range), .err_tmo(err_tmo),
      .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Launch a run and hold busy high; bounded wait for the ready pulse.
   task automatic go_run();
      bit seen = 0;
      do_start();
      for (int k = 0; k < 32; k++) begin
         if (ready) begin seen = 1; break; end
         tick();
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL go_run_ready: ready not seen within 32 cycles, got 0 want 1");
      end
      busy = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if ({ready, done, err_proto, err_csel, err_range, err_tmo} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000000",
                  {ready, done, err_proto, err_csel, err_range, err_tmo});
      end
      total++;
      if (wr_cnt_l0 !== 13'd0 || wr_cnt_l1 !== 11'd0) begin
         bad++;
         $display("FAIL reset_counters: got l0=%0d l1=%0d want 0 0", wr_cnt_l0, wr_cnt_l1);
      end
      total++;
      if (cdata_rd !== 20'h0) begin
         bad++;
         $display("FAIL reset_cdata_rd: got %h want 00000", cdata_rd);
      end
   endtask

   // Load and start in the same cycle; ready must pulse exactly 3 cycles later.
   task automatic test_load_ready();
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0100;
      ld_en = 1'b1; ld_addr = 12'h041; ld_data = 20'h0ABCD;
      exp_q.push_back(20'h0ABCD);
      start = 1'b1;
      tick();
      ld_en = 1'b0; start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         total++;
         if (ready !== exp_rdy[c-1]) begin
            bad++;
            $display("FAIL ready_cycle%0d: got %b want %b", c, ready, exp_rdy[c-1]);
         end
         if (c == 3) busy = 1'b1;
         iaddr = 12'h041;
         #1;
         if (c == 3) begin
            exp_w = exp_q.pop_front();
            total++;
            if (idata !== exp_w) begin
               bad++;
               $display("FAIL idata_041: got %h want %h", idata, exp_w);
            end
         end
         if (c < 4) tick();
      end
      total++;
      if (err_proto !== 1'b0) begin
         bad++;
         $display("FAIL load_with_start_proto: got %b want 0", err_proto);
      end
   endtask

   task automatic test_l0_write();
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h7FF; cdata_wr = 20'h12345;
      exp_q.push_back(20'h12345);
      tick();
      cwr = 1'b0;
      dp_sel = 1'b0; dp_addr = 12'h7FF;
      #1;
      exp_w = exp_q.pop_front();
      total++;
      if (dp_data !== exp_w) begin
         bad++;
         $display("FAIL dp_l0_7ff: got %h want %h", dp_data, exp_w);
      end
      total++;
      if (wr_cnt_l0 !== 13'd1) begin
         bad++;
         $display("FAIL wr_cnt_l0_one: got %0d want 1", wr_cnt_l0);
      end
      // Same-address write and read: read returns the pre-edge word.
      exp_q.push_back(20'h12345);
      exp_q.push_back(20'h54321);
      cwr = 1'b1; cdata_wr = 20'h54321; crd = 1'b1; caddr_rd = 12'h7FF;
      #1;
      exp_w = exp_q.pop_front();
      total++;
      if (cdata_rd !== exp_w) begin
         bad++;
         $display("FAIL rd_during_wr: got %h want %h", cdata_rd, exp_w);
      end
      tick();
      cwr = 1'b0; crd = 1'b0;
      #1;
      total++;
      if (cdata_rd !== exp_w) begin
         bad++;
         $display("FAIL rd_hold: got %h want %h", cdata_rd, exp_w);
      end
      exp_w = exp_q.pop_front();
      total++;
      if (dp_data !== exp_w || wr_cnt_l0 !== 13'd2) begin
         bad++;
         $display("FAIL overwrite: got %h cnt=%0d want %h cnt=2", dp_data, wr_cnt_l0, exp_w);
      end
   endtask

   task automatic test_l1_errors();
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'h77777;
      tick();
      cwr = 1'b0;
      total++;
      if (err_range !== 1'b1 || wr_cnt_l1 !== 11'd0) begin
         bad++;
         $display("FAIL l1_range: got err_range=%b cnt=%0d want 1 0", err_range, wr_cnt_l1);
      end
      crd = 1'b1; csel = 3'b010; caddr_rd = 12'h000;
      tick();
      crd = 1'b0;
      total++;
      if (err_csel !== 1'b1) begin
         bad++;
         $display("FAIL csel_010: got err_csel=%b want 1", err_csel);
      end
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'hC0FFE;
      exp_q.push_back(20'hC0FFE);
      tick();
      cwr = 1'b0;
      crd = 1'b1; caddr_rd = 12'h3FF;
      #1;
      exp_w = exp_q.pop_front();
      total++;
      if (cdata_rd !== exp_w || wr_cnt_l1 !== 11'd1) begin
         bad++;
         $display("FAIL l1_read: got %h cnt=%0d want %h cnt=1", cdata_rd, wr_cnt_l1, exp_w);
      end
      crd = 1'b0;
      tick();
      busy = 1'b0;
      #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL done_early: got %b want 0", done);
      end
      tick();
      total++;
      if (done !== 1'b1 || err_range !== 1'b1 || err_csel !== 1'b1 || err_proto !== 1'b0) begin
         bad++;
         $display("FAIL run_end: got done=%b range=%b csel=%b proto=%b want 1 1 1 0",
                  done, err_range, err_csel, err_proto);
      end
   endtask

   task automatic test_timeout();
      bit seen = 0;
      do_start();
      total++;
      if ({done, err_proto, err_csel, err_range, err_tmo} !== 5'b0 ||
          wr_cnt_l0 !== 13'd0 || wr_cnt_l1 !== 11'd0) begin
         bad++;
         $display("FAIL start_clears: got flags=%b l0=%0d l1=%0d want 00000 0 0",
                  {done, err_proto, err_csel, err_range, err_tmo}, wr_cnt_l0, wr_cnt_l1);
      end
      for (int k = 0; k < 32; k++) begin
         if (ready) begin seen = 1; break; end
         tick();
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL tmo_ready: ready not seen within 32 cycles, got 0 want 1");
      end
      for (int k = 0; k < 1022; k++) tick();
      total++;
      if (done !== 1'b0 || err_tmo !== 1'b0) begin
         bad++;
         $display("FAIL tmo_early: got done=%b err_tmo=%b want 0 0", done, err_tmo);
      end
      tick();
      total++;
      if (done !== 1'b1 || err_tmo !== 1'b1) begin
         bad++;
         $display("FAIL tmo_fire: got done=%b err_tmo=%b want 1 1", done, err_tmo);
      end
      // Load accepted without protocol error confirms the FSM sits in DONE.
      ld_en = 1'b1; ld_addr = 12'h000; ld_data = 20'h00001;
      tick();
      ld_en = 1'b0;
      total++;
      if (err_proto !== 1'b0 || done !== 1'b1) begin
         bad++;
         $display("FAIL tmo_state_done: got proto=%b done=%b want 0 1", err_proto, done);
      end
   endtask

   task automatic test_fill_counters();
      go_run();
      csel = 3'b001;
      for (int i = 0; i < 4096; i++) begin
         cwr = 1'b1; caddr_wr = 12'(i); cdata_wr = {8'hA5, 12'(i)};
         exp_q.push_back({8'hA5, 12'(i)});
         tick();
      end
      // Two extra rewrites with identical data exercise saturation only.
      for (int i = 0; i < 2; i++) begin
         caddr_wr = 12'(i); cdata_wr = {8'hA5, 12'(i)};
         tick();
      end
      csel = 3'b011;
      for (int i = 0; i < 1025; i++) begin
         caddr_wr = 12'(i % 1024); cdata_wr = {8'h3C, 12'(i % 1024)};
         if (i < 1024) exp_q.push_back({8'h3C, 12'(i)});
         tick();
      end
      cwr = 1'b0;
      total++;
      if (wr_cnt_l0 !== 13'd4096 || wr_cnt_l1 !== 11'd1024) begin
         bad++;
         $display("FAIL saturate: got l0=%0d l1=%0d want 4096 1024", wr_cnt_l0, wr_cnt_l1);
      end
      busy = 1'b0;
      tick();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL fill_done: got %b want 1", done);
      end
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h000; cdata_wr = 20'hFFFFF;
      tick();
      cwr = 1'b0;
      total++;
      if (err_proto !== 1'b1 || wr_cnt_l0 !== 13'd4096 || wr_cnt_l1 !== 11'd1024) begin
         bad++;
         $display("FAIL cwr_after_done: got proto=%b l0=%0d l1=%0d want 1 4096 1024",
                  err_proto, wr_cnt_l0, wr_cnt_l1);
      end
      dp_sel = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         dp_addr = 12'(i);
         #1;
         exp_w = exp_q.pop_front();
         total++;
         if (dp_data !== exp_w) begin
            bad++;
            $display("FAIL dump_l0[%0d]: got %h want %h", i, dp_data, exp_w);
         end
      end
      dp_sel = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         dp_addr = 12'(i);
         #1;
         exp_w = exp_q.pop_front();
         total++;
         if (dp_data !== exp_w) begin
            bad++;
            $display("FAIL dump_l1[%0d]: got %h want %h", i, dp_data, exp_w);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      go_run();
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'h0BEEF;
      exp_q.push_back(20'h0BEEF);
      tick();
      cwr = 1'b0;
      crd = 1'b1; csel = 3'b000;
      tick();
      crd = 1'b0;
      // Reset edge carries a write that must not land.
      reset = 1'b1;
      cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h123; cdata_wr = 20'hFFFFF;
      tick();
      reset = 1'b0; cwr = 1'b0; busy = 1'b0;
      total++;
      if ({ready, done, err_proto, err_csel, err_range, err_tmo} !== 6'b0 ||
          wr_cnt_l0 !== 13'd0 || wr_cnt_l1 !== 11'd0 || cdata_rd !== 20'h0) begin
         bad++;
         $display("FAIL mid_run_reset: got flags=%b l0=%0d l1=%0d rd=%h want 000000 0 0 00000",
                  {ready, done, err_proto, err_csel, err_range, err_tmo},
                  wr_cnt_l0, wr_cnt_l1, cdata_rd);
      end
      dp_sel = 1'b0; dp_addr = 12'h123;
      #1;
      exp_w = exp_q.pop_front();
      total++;
      if (dp_data !== exp_w) begin
         bad++;
         $display("FAIL l0_survives_reset: got %h want %h", dp_data, exp_w);
      end
      ld_en = 1'b1; ld_addr = 12'h001; ld_data = 20'h00002;
      tick();
      ld_en = 1'b0;
      total++;
      if (err_proto !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_to_idle: got proto=%b done=%b want 0 0", err_proto, done);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; ld_en = 1'b0; busy = 1'b0;
      cwr = 1'b0; crd = 1'b0; dp_sel = 1'b0; csel = 3'b000;
      ld_addr = '0; iaddr = '0; caddr_wr = '0; caddr_rd = '0; dp_addr = '0;
      ld_data = '0; cdata_wr = '0;

      test_reset();
      test_load_ready();
      test_l0_write();
      test_l1_errors();
      test_timeout();
      test_fill_counters();
      test_reset_mid_run();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
